// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared constants and helpers for the instruction fetch front end.
//   - INST_W / PC_W   : instruction and program-counter widths
//   - NOP_INST        : value presented on IF_Inst while nothing is buffered
//   - PC_INC          : fetch stride (one 32-bit word)
//   - DEPTH_DEF       : default FIFO depth / request credit
//   - cnt_width()     : width of a counter that must hold 0..depth inclusive
//   - ptr_width()     : width of a FIFO pointer for a power-of-2 depth
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int INST_W  = 32;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = PC_W + INST_W;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [PC_W-1:0]   PC_INC   = 32'd4;

  localparam int DEPTH_DEF = 4;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fq_fifo
//   Synchronous FIFO of DEPTH entries, ENTRY_W bits each, with flush.
//   The head entry is held in a register (head_q) that is recomputed every
//   cycle, so head_o never has a combinational path from push/pop inputs.
//   head_o reads as all-zero whenever the FIFO is empty.
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_ni       asynchronous active-low reset
//     flush_i      discard all entries (overrides push and pop)
//     push_i       write push_data_i (ignored when full and not popping)
//     push_data_i  entry to write
//     pop_i        remove the head entry (ignored when empty)
//     count_o      number of valid entries, 0..DEPTH
//     head_o       oldest entry, zero when empty
// -----------------------------------------------------------------------------
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [ENTRY_W-1:0]      push_data_i,
  input  logic                    pop_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [ENTRY_W-1:0]      head_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               do_push, do_pop;

  // A full FIFO may still accept a push in the same cycle it pops.
  assign do_pop  = pop_i  && !flush_i && (count_q != '0);
  assign do_push = push_i && !flush_i && ((count_q != FULL) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
    // The new head is the word being written exactly when it lands on the
    // new read pointer (queue was empty, or drained to empty this cycle).
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch front end feeding the IF/ID register. Owns the fetch PC,
//   issues in-order word fetches to instruction memory, buffers returned words
//   in fq_fifo and presents {PC+4, instruction} downstream. A Redirect flushes
//   the buffer, retargets fetch and marks every in-flight read as stale.
//
//   Handshakes:
//     Imem_Req/Imem_Gnt - a request transfers in a cycle where both are high.
//       Once raised, Req and Addr hold until granted; only Redirect may
//       withdraw a pending request. Imem_RValid returns one word per cycle in
//       request order with no back-pressure; the credit rule below guarantees
//       buffer space for every outstanding read.
//     IF_Valid/Stall    - the head entry is consumed in a cycle where
//       IF_Valid is high and Stall is low.
//
//   Ports:
//     Clk, Rst              clock; asynchronous active-low reset
//     Imem_Req, Imem_Addr   fetch request and word-aligned address
//     Imem_Gnt              memory accepts the request this cycle
//     Imem_RValid, RData    returned instruction word
//     Redirect, Redirect_PC branch/jump retarget from ID
//     Stall                 downstream cannot accept
//     IF_Valid, IF_PC, IF_Inst  head entry (PC+4 and instruction)
//
//   Optional build macro FETCH_QUEUE_STATS_EN adds saturating counters:
//     Stat_Discard   stale responses dropped
//     Stat_StallCyc  cycles with IF_Valid && Stall
//     Stat_Empty     cycles with !IF_Valid and no Redirect
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Gnt,
  input  logic        Imem_RValid,
  input  logic [31:0] Imem_RData,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  input  logic        Stall,
  output logic        IF_Valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Inst
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] Stat_Discard,
  output logic [31:0] Stat_StallCyc,
  output logic [31:0] Stat_Empty
`endif
);

  localparam int              CNT_W  = cnt_width(DEPTH);
  localparam logic [CNT_W:0]  CREDIT = (CNT_W+1)'(DEPTH);

  logic [PC_W-1:0]    fpc_q, fpc_d;     // next address to request
  logic [PC_W-1:0]    rpc_q, rpc_d;     // address of the next accepted response
  logic [CNT_W-1:0]   out_q, out_d;     // reads granted but not yet returned
  logic [CNT_W-1:0]   disc_q, disc_d;   // returns still owed to a past redirect
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W:0]     inflight;
  logic [PC_W-1:0]    target_pc;
  logic               issue, rsp, drop, accept, pop;

  assign target_pc = Redirect_PC & ~32'h3;

  // Every granted read has a guaranteed FIFO slot, so overflow cannot occur.
  assign inflight  = {1'b0, out_q} + {1'b0, fifo_count};
  assign Imem_Req  = Rst && !Redirect && (inflight < CREDIT);
  assign Imem_Addr = fpc_q;

  assign issue  = Imem_Req && Imem_Gnt;
  assign rsp    = Imem_RValid && (out_q != '0);
  assign drop   = rsp && (disc_q != '0);
  assign accept = rsp && !drop && !Redirect;
  assign pop    = IF_Valid && !Stall && !Redirect;

  always_comb begin
    fpc_d  = fpc_q;
    rpc_d  = rpc_q;
    out_d  = out_q;
    disc_d = disc_q;
    if (Redirect) begin
      fpc_d  = target_pc;
      rpc_d  = target_pc;
      out_d  = out_q - {{(CNT_W-1){1'b0}}, rsp};
      // Everything still outstanding after this cycle belongs to the old path.
      disc_d = out_d;
    end else begin
      if (issue)  fpc_d = fpc_q + PC_INC;
      if (accept) rpc_d = rpc_q + PC_INC;
      out_d = out_q + {{(CNT_W-1){1'b0}}, issue} - {{(CNT_W-1){1'b0}}, rsp};
      if (drop) disc_d = disc_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fpc_q  <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (Clk),
    .rst_ni      (Rst),
    .flush_i     (Redirect),
    .push_i      (accept),
    .push_data_i ({rpc_q + PC_INC, Imem_RData}),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign IF_Valid = (fifo_count != '0);
  assign IF_PC    = fifo_head[ENTRY_W-1:INST_W];
  assign IF_Inst  = IF_Valid ? fifo_head[INST_W-1:0] : NOP_INST;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_discard_q, stat_stall_q, stat_empty_q;
  logic        stale_drop;

  // A response arriving with a redirect is dropped as well as a counted stale one.
  assign stale_drop = rsp && ((disc_q != '0) || Redirect);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stat_discard_q <= '0;
      stat_stall_q   <= '0;
      stat_empty_q   <= '0;
    end else begin
      if (stale_drop && (stat_discard_q != '1))
        stat_discard_q <= stat_discard_q + 32'd1;
      if (IF_Valid && Stall && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
      if (!IF_Valid && !Redirect && (stat_empty_q != '1))
        stat_empty_q <= stat_empty_q + 32'd1;
    end
  end

  assign Stat_Discard  = stat_discard_q;
  assign Stat_StallCyc = stat_stall_q;
  assign Stat_Empty    = stat_empty_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Bench for fetch_queue. A behavioural memory answers granted reads in order
//   after a per-request latency. The reference model tags each in-flight read
//   as stale when a redirect happens and keeps the expected IF stream as a
//   queue of {PC+4, instruction}; every cycle the DUT is compared with it.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk, Rst;
  logic        Imem_Req, Imem_Gnt, Imem_RValid;
  logic [31:0] Imem_Addr, Imem_RData;
  logic        Redirect, Stall;
  logic [31:0] Redirect_PC;
  logic        IF_Valid;
  logic [31:0] IF_PC, IF_Inst;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_discard, stat_stall, stat_empty;
`endif

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Imem_Gnt    (Imem_Gnt),
    .Imem_RValid (Imem_RValid),
    .Imem_RData  (Imem_RData),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .Stall       (Stall),
    .IF_Valid    (IF_Valid),
    .IF_PC       (IF_PC),
    .IF_Inst     (IF_Inst)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .Stat_Discard  (stat_discard),
    .Stat_StallCyc (stat_stall),
    .Stat_Empty    (stat_empty)
`endif
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;   // address the DUT actually requested
    logic [31:0] eaddr;  // address the model expected at that point
    bit          stale;
    int          ready;
  } mreq_t;

  mreq_t       mq[$];        // reads granted, not yet returned
  logic [63:0] exp_q[$];     // expected IF entries {pc+4, inst}
  logic [31:0] exp_fetch;
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];
  int          cyc;
  int          lat_lo, lat_hi;
  bit          spurious_en;
  int          first_req_cyc, first_valid_cyc;
  int          n_checks, n_errors;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] log_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit gnt, input bit redir, input logic [31:0] rpc, input bit stall);
    bit          rsp, exp_req, issue, pop;
    mreq_t       head, nr;
    logic [63:0] tmp;
    @(posedge Clk);
    #1;
    cyc++;
    Imem_Gnt    = gnt;
    Redirect    = redir;
    Redirect_PC = rpc;
    Stall       = stall;
    rsp = (mq.size() != 0) && (mq[0].ready <= cyc);
    if (rsp) begin
      Imem_RValid = 1'b1;
      Imem_RData  = inst_of(mq[0].addr);
    end else if (spurious_en && (mq.size() == 0) && ($urandom_range(0, 7) == 0)) begin
      Imem_RValid = 1'b1;
      Imem_RData  = $urandom;
    end else begin
      Imem_RValid = 1'b0;
      Imem_RData  = '0;
    end
    #3;
    // scoreboard comparisons
    exp_req = ((mq.size() + exp_q.size()) < DEPTH) && !redir;
    check("imem_req", Imem_Req, exp_req);
    check("imem_addr", Imem_Addr, exp_fetch);
    check("if_valid", IF_Valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("if_pc", IF_PC, exp_q[0][63:32]);
      check("if_inst", IF_Inst, exp_q[0][31:0]);
    end else begin
      check("if_inst_nop", IF_Inst, 32'h0);
    end
    // observation logs for directed checks
    if (Imem_Req && gnt) grant_log.push_back(Imem_Addr);
    if (IF_Valid && !stall && !redir) pop_log.push_back(IF_PC);
    if (Imem_Req && (first_req_cyc < 0)) first_req_cyc = cyc;
    if (IF_Valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
    // model update for the coming edge
    pop   = (exp_q.size() != 0) && !stall && !redir;
    issue = Imem_Req && gnt;
    if (rsp) head = mq.pop_front();
    if (redir) begin
      exp_q.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      exp_fetch = rpc & ~32'h3;
    end else begin
      if (pop) tmp = exp_q.pop_front();
      if (rsp && !head.stale) exp_q.push_back({head.eaddr + 32'd4, inst_of(head.eaddr)});
      if (issue) begin
        nr.addr  = Imem_Addr;
        nr.eaddr = exp_fetch;
        nr.stale = 1'b0;
        nr.ready = cyc + int'($urandom_range(lat_lo, lat_hi));
        mq.push_back(nr);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  endtask

  task automatic run(input int n, input bit gnt, input bit stall);
    for (int i = 0; i < n; i++) step(gnt, 1'b0, 32'h0, stall);
  endtask

  // Assert reset asynchronously a little after an edge; the memory drops its reads.
  task automatic apply_reset();
    @(posedge Clk);
    #2;
    Rst         = 1'b0;
    Imem_Gnt    = 1'b0;
    Imem_RValid = 1'b0;
    Imem_RData  = '0;
    Redirect    = 1'b0;
    Redirect_PC = '0;
    Stall       = 1'b0;
    #1;
    check("rst_req", Imem_Req, 1'b0);
    check("rst_addr", Imem_Addr, RESET_PC);
    check("rst_valid", IF_Valid, 1'b0);
    check("rst_pc", IF_PC, 32'h0);
    check("rst_inst", IF_Inst, 32'h0);
    mq.delete();
    exp_q.delete();
    exp_fetch = RESET_PC;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    Rst = 1'b0; Imem_Gnt = 1'b0; Imem_RValid = 1'b0; Imem_RData = '0;
    Redirect = 1'b0; Redirect_PC = '0; Stall = 1'b0;
    cyc = 0; n_checks = 0; n_errors = 0;
    lat_lo = 1; lat_hi = 1; spurious_en = 1'b0;
    exp_fetch = RESET_PC;
    first_req_cyc = -1; first_valid_cyc = -1;

    // Reset release, 1-cycle memory, always granted, never stalled.
    apply_reset();
    grant_log.delete(); pop_log.delete();
    run(8, 1'b1, 1'b0);
    check("boot_addr0", log_at(grant_log, 0), 32'h0);
    check("boot_addr1", log_at(grant_log, 1), 32'h4);
    check("boot_addr2", log_at(grant_log, 2), 32'h8);
    check("boot_pc0", log_at(pop_log, 0), 32'h4);
    check("boot_pc1", log_at(pop_log, 1), 32'h8);
    check("boot_pc2", log_at(pop_log, 2), 32'hC);
    // request -> response -> visible: two cycles from the first request
    check("boot_valid_lat", first_valid_cyc - first_req_cyc, 2);

    // Redirect to an unaligned target with two reads in flight.
    lat_lo = 2; lat_hi = 2;
    run(6, 1'b1, 1'b0);
    check("inflight_pre_redirect", mq.size(), 2);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    grant_log.delete(); pop_log.delete();
    run(6, 1'b1, 1'b0);
    check("redir_addr", log_at(grant_log, 0), 32'h0000_0100);
    check("redir_pc", log_at(pop_log, 0), 32'h0000_0104);

    // Redirect latency with 1-cycle memory: target visible three cycles later.
    lat_lo = 1; lat_hi = 1;
    run(3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0500, 1'b0);
    first_valid_cyc = -1;
    pop_log.delete();
    run(4, 1'b1, 1'b0);
    check("redir_valid_lat", first_valid_cyc, cyc - 1);
    check("redir_lat_pc", log_at(pop_log, 0), 32'h0000_0504);

    // Grant withheld while Req holds; a redirect in the third cycle withdraws it.
    step(1'b0, 1'b1, 32'h0000_0008, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    grant_log.delete(); pop_log.delete();
    run(6, 1'b1, 1'b0);
    check("nognt_addr", log_at(grant_log, 0), 32'h0000_0040);
    check("nognt_pc", log_at(pop_log, 0), 32'h0000_0044);

    // Fetch address wraps at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    grant_log.delete(); pop_log.delete();
    run(8, 1'b1, 1'b0);
    check("wrap_addr1", log_at(grant_log, 1), 32'hFFFF_FFFC);
    check("wrap_addr2", log_at(grant_log, 2), 32'h0000_0000);
    check("wrap_pc0", log_at(pop_log, 0), 32'hFFFF_FFFC);
    check("wrap_pc1", log_at(pop_log, 1), 32'h0000_0000);

    // Redirect, response and pop all in one cycle.
    run(4, 1'b1, 1'b0);
    check("same_cyc_valid", IF_Valid, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b0);
    pop_log.delete();
    run(6, 1'b1, 1'b0);
    check("same_cyc_pc", log_at(pop_log, 0), 32'h0000_0304);

    // Randomized traffic: variable latency, random grant/stall/redirect.
    lat_lo = 1; lat_hi = 4; spurious_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 3);
    end
    spurious_en = 1'b0;

    // Reset mid-burst with three reads outstanding.
    step(1'b0, 1'b1, 32'h0000_2000, 1'b0);
    run(10, 1'b0, 1'b0);
    lat_lo = 3; lat_hi = 3;
    run(3, 1'b1, 1'b1);
    check("inflight_pre_reset", mq.size(), 3);
    apply_reset();

    // Held stall after reset: exactly DEPTH requests, head stays at RESET_PC+4.
    lat_lo = 1; lat_hi = 1;
    grant_log.delete(); pop_log.delete();
    run(10, 1'b1, 1'b1);
    check("stall_grants", grant_log.size(), DEPTH);
    check("stall_first_addr", log_at(grant_log, 0), RESET_PC);
    check("stall_head_pc", IF_PC, RESET_PC + 32'd4);
    run(20, 1'b1, 1'b0);
    check("drain_pc0", log_at(pop_log, 0), RESET_PC + 32'h4);
    check("drain_pc1", log_at(pop_log, 1), RESET_PC + 32'h8);
    check("drain_pc2", log_at(pop_log, 2), RESET_PC + 32'hC);
    check("drain_pc3", log_at(pop_log, 3), RESET_PC + 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
